// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory access path: access sizes and the
// state encoding of the sub-word store sequencer in mem_access_unit.
package mips_mem_pkg;

    // Access size as carried on req_size; 2'b11 is reserved and handled as a word.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Sub-word store sequencer: IDLE serves every access in one cycle, READ
    // fetches the target word, WRITE stores the merged word.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10
    } mau_state_e;

    // Sizes that require a read-modify-write when stored.
    function automatic logic is_subword(input logic [1:0] size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

endpackage

// File: rtl/mau_lane_ext.sv
// Load-data lane selection: picks the addressed byte or half out of a 32-bit
// little-endian memory word and sign- or zero-extends it to 32 bits.
// Word (and reserved) sizes pass the word through unchanged.
module mau_lane_ext
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane and extend it according to sign_ext.
    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        data     = word;
        case (size)
            SZ_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end for the 1 KB data memory of the single-cycle MIPS core.
// Loads and word stores complete in the request cycle; byte/half stores run a
// three-cycle read-modify-write (IDLE -> READ -> WRITE) while stalling the core.
// Optional build macro: MAU_ALIGN_CHECK_EN enables the alignment fault
// (misalign) and suppresses faulting accesses; otherwise misalign is tied low
// and unused low address bits are ignored.
//
// Handshake: a request is taken whenever req_valid is high in IDLE; the core
// must hold the instruction while stall is high, and it retires the access on
// the first rising edge at which stall is low. While READ/WRITE run, req_* are
// ignored and only the captured cap_* values are used.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout,
    output mau_state_e        dbg_state
);

    mau_state_e        state;
    mau_state_e        state_nxt;

    // Captured sub-word store; only the low half of the store data can ever
    // land in memory, so only that much is kept.
    logic [ADDR_W-1:0] cap_addr;
    logic [1:0]        cap_size;
    logic [15:0]       cap_wdata;
    logic              cap_load;
    logic [31:0]       rd_buf;

    logic [ADDR_W-1:0] req_word_addr;
    logic [ADDR_W-1:0] cap_word_addr;
    logic [31:0]       ext_data;
    logic [31:0]       merged;
    logic              mis_req;
    logic              dm_we_raw;
    logic              unused_addr_hi;

    assign req_word_addr  = {req_addr[ADDR_W-1:2], 2'b00};
    assign cap_word_addr  = {cap_addr[ADDR_W-1:2], 2'b00};
    assign unused_addr_hi = ^req_addr[31:ADDR_W];
    assign dbg_state      = state;

`ifdef MAU_ALIGN_CHECK_EN
    // Misaligned half/word requests fault in IDLE and are not performed.
    always_comb begin
        mis_req = 1'b0;
        if (req_valid && (state == ST_IDLE)) begin
            if (req_size == SZ_HALF)
                mis_req = req_addr[0];
            else if (req_size[1])
                mis_req = (req_addr[1:0] != 2'b00);
        end
    end
`else
    // Without the alignment check every access is performed on its word.
    always_comb begin
        mis_req = 1'b0;
    end
`endif

    assign misalign = mis_req;

    mau_lane_ext u_lane_ext (
        .word     (dm_dout),
        .offset   (req_addr[1:0]),
        .size     (req_size),
        .sign_ext (req_signed),
        .data     (ext_data)
    );

    // Replace the addressed lane of the fetched word with the captured data.
    always_comb begin
        merged = rd_buf;
        if (cap_size == SZ_BYTE)
            merged[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
        else if (cap_size == SZ_HALF)
            merged[{cap_addr[1], 4'b0000} +: 16] = cap_wdata;
    end

    // Next-state and memory-port/core outputs for the sequencer.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        dm_we_raw = 1'b0;
        dm_addr   = '0;
        dm_din    = '0;
        rdata     = '0;
        cap_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && !mis_req) begin
                    dm_addr = req_word_addr;
                    if (!req_we) begin
                        rdata = ext_data;
                    end else if (is_subword(req_size)) begin
                        stall     = 1'b1;
                        cap_load  = 1'b1;
                        state_nxt = ST_READ;
                    end else begin
                        dm_we_raw = 1'b1;
                        dm_din    = req_wdata;
                    end
                end
            end
            ST_READ: begin
                dm_addr   = cap_word_addr;
                stall     = 1'b1;
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                dm_addr   = cap_word_addr;
                dm_din    = merged;
                dm_we_raw = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reset drops the write enable at once so an aborted store writes nothing.
    assign dm_we = dm_we_raw & rst_n;

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Capture the sub-word store when the sequence starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_addr  <= '0;
            cap_size  <= SZ_BYTE;
            cap_wdata <= '0;
        end else if (cap_load) begin
            cap_addr  <= req_addr[ADDR_W-1:0];
            cap_size  <= req_size;
            cap_wdata <= req_wdata[15:0];
        end
    end

    // Hold the word fetched during READ for the merge in WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_buf <= '0;
        else if (state == ST_READ)
            rd_buf <= dm_dout;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a 1 KB word memory modelled in the
// bench drives dm_dout, and a separate reference memory tracks the
// architecturally expected contents. Honours MAU_ALIGN_CHECK_EN like the RTL.
module tb_mem_access_unit;
    import mips_mem_pkg::*;

    localparam int ADDR_W = 10;

    int checks   = 0;
    int failures = 0;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              stall;
    logic [31:0]       rdata;
    logic              misalign;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_din;
    logic              dm_we;
    logic [31:0]       dm_dout;
    mau_state_e        dbg_state;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    // Observations of the last driven access.
    logic              obs_stall [4];
    logic              obs_we    [4];
    logic [31:0]       obs_rdata;
    logic [31:0]       obs_din;
    logic [31:0]       obs_wdin;
    logic [ADDR_W-1:0] obs_addr;
    logic [ADDR_W-1:0] obs_waddr;
    logic              obs_mis;
    int                obs_ncyc;

    logic mon_en  = 1'b0;
    logic we_seen = 1'b0;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rdata      (rdata),
        .misalign   (misalign),
        .dm_addr    (dm_addr),
        .dm_din     (dm_din),
        .dm_we      (dm_we),
        .dm_dout    (dm_dout),
        .dbg_state  (dbg_state)
    );

    // Clock and data memory.
    always #5 clk = ~clk;
    assign dm_dout = mem[dm_addr[ADDR_W-1:2]];
    always @(posedge clk) if (dm_we === 1'b1) mem[dm_addr[ADDR_W-1:2]] <= dm_din;
    always @(posedge clk) if (mon_en && dm_we !== 1'b0) we_seen <= 1'b1;

    // The memory must never be written while the word is being fetched.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dbg_state == ST_READ) begin
            checks++;
            if (dm_we !== 1'b0) begin
                failures++;
                $display("FAIL we_in_read: dm_we=%b required 0", dm_we);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        logic [31:0] w;
        logic [31:0] v;
        int sh;
        w = ref_mem[a[9:2]];
        if (sz == 2'b00) begin
            sh = 8 * a[1:0];
            v  = (w >> sh) & 32'hFF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            sh = a[1] ? 16 : 0;
            v  = (w >> sh) & 32'hFFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        if (sz == 2'b00) begin
            sh   = 8 * a[1:0];
            mask = 32'hFF << sh;
            return (w & ~mask) | ((d & 32'hFF) << sh);
        end
        sh   = a[1] ? 16 : 0;
        mask = 32'hFFFF << sh;
        return (w & ~mask) | ((d & 32'hFFFF) << sh);
    endfunction

    function automatic logic ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
`ifdef MAU_ALIGN_CHECK_EN
        if (sz == 2'b01) return a[0];
        if (sz[1]) return a[1:0] != 2'b00;
        return 1'b0;
`else
        return 1'b0 & a[0] & sz[0];
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_nop();
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b00;
        req_signed = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        #1;
        obs_rdata = rdata;
        obs_we[0] = dm_we;
        obs_stall[0] = stall;
        obs_mis   = misalign;
    endtask

    // Present one access and follow it until stall drops (at most 4 cycles).
    // While stalled the request lines are scrambled: the DUT must ignore them.
    task automatic drive_access(input logic we, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] d);
        int n;
        for (int i = 0; i < 4; i++) begin
            obs_stall[i] = 1'b0;
            obs_we[i]    = 1'b0;
        end
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_signed = sg;
        req_addr  = a;
        req_wdata = d;
        #1;
        obs_stall[0] = stall;
        obs_we[0]    = dm_we;
        obs_rdata    = rdata;
        obs_mis      = misalign;
        obs_addr     = dm_addr;
        obs_din      = dm_din;
        obs_wdin     = dm_din;
        obs_waddr    = dm_addr;
        n = 1;
        while (obs_stall[n-1] === 1'b1 && n < 4) begin
            @(negedge clk);
            req_valid  = 1'($urandom_range(0, 1));
            req_we     = 1'($urandom_range(0, 1));
            req_size   = 2'($urandom_range(0, 3));
            req_signed = 1'($urandom_range(0, 1));
            req_addr   = $urandom;
            req_wdata  = $urandom;
            #1;
            obs_stall[n] = stall;
            obs_we[n]    = dm_we;
            obs_wdin     = dm_din;
            obs_waddr    = dm_addr;
            n++;
        end
        obs_ncyc = n;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        #12;
        checks++;
        if ({stall, dm_we, misalign} !== 3'b000 || rdata !== 32'h0 || dm_din !== 32'h0
            || dm_addr !== '0 || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_outputs: stall=%b we=%b mis=%b rdata=%h din=%h addr=%h state=%0d required all 0",
                     stall, dm_we, misalign, rdata, dm_din, dm_addr, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word_store();
        drive_access(1'b1, SZ_WORD, 1'b0, 32'h010, 32'hDEADBEEF);
        ref_mem[4] = 32'hDEADBEEF;
        checks++;
        if (obs_ncyc != 1 || obs_stall[0] !== 1'b0 || obs_we[0] !== 1'b1
            || obs_addr !== 10'h010 || obs_din !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL sw_010: cyc=%0d stall=%b we=%b addr=%h din=%h required 1 0 1 010 deadbeef",
                     obs_ncyc, obs_stall[0], obs_we[0], obs_addr, obs_din);
        end
    endtask

    task automatic test_byte_store();
        mem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
        drive_access(1'b1, SZ_BYTE, 1'b0, 32'h021, 32'h000000AA);
        ref_mem[8] = 32'h1122AA44;
        checks++;
        if (obs_ncyc != 3 || {obs_stall[0], obs_stall[1], obs_stall[2]} !== 3'b110
            || {obs_we[0], obs_we[1], obs_we[2]} !== 3'b001) begin
            failures++;
            $display("FAIL sb_sequence: cyc=%0d stall=%b%b%b we=%b%b%b required 3 110 001", obs_ncyc,
                     obs_stall[0], obs_stall[1], obs_stall[2], obs_we[0], obs_we[1], obs_we[2]);
        end
        checks++;
        if (obs_wdin !== 32'h1122AA44 || obs_waddr !== 10'h020) begin
            failures++;
            $display("FAIL sb_write_word: din=%h addr=%h required 1122aa44 020", obs_wdin, obs_waddr);
        end
        drive_access(1'b0, SZ_WORD, 1'b0, 32'h020, 32'h0);
        checks++;
        if (obs_rdata !== 32'h1122AA44 || obs_stall[0] !== 1'b0) begin
            failures++;
            $display("FAIL lw_after_sb: rdata=%h stall=%b required 1122aa44 0", obs_rdata, obs_stall[0]);
        end
    endtask

    task automatic test_byte_load();
        mem[12] = 32'h80223344; ref_mem[12] = 32'h80223344;
        drive_access(1'b0, SZ_BYTE, 1'b1, 32'h033, 32'h0);
        checks++;
        if (obs_rdata !== 32'hFFFFFF80 || obs_stall[0] !== 1'b0) begin
            failures++;
            $display("FAIL lb_033: rdata=%h stall=%b required ffffff80 0", obs_rdata, obs_stall[0]);
        end
        drive_access(1'b0, SZ_BYTE, 1'b0, 32'h033, 32'h0);
        checks++;
        if (obs_rdata !== 32'h00000080 || obs_stall[0] !== 1'b0) begin
            failures++;
            $display("FAIL lbu_033: rdata=%h stall=%b required 00000080 0", obs_rdata, obs_stall[0]);
        end
    endtask

    task automatic test_half_store_load();
        mem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
        drive_access(1'b1, SZ_HALF, 1'b0, 32'h022, 32'h0000BEEF);
        ref_mem[8] = 32'hBEEF3344;
        checks++;
        if (obs_ncyc != 3 || obs_wdin !== 32'hBEEF3344 || obs_we[2] !== 1'b1) begin
            failures++;
            $display("FAIL sh_022: cyc=%0d din=%h we=%b required 3 beef3344 1", obs_ncyc, obs_wdin, obs_we[2]);
        end
        drive_access(1'b0, SZ_HALF, 1'b1, 32'h022, 32'h0);
        checks++;
        if (obs_rdata !== 32'hFFFFBEEF) begin
            failures++;
            $display("FAIL lh_022: rdata=%h required ffffbeef", obs_rdata);
        end
        drive_access(1'b0, SZ_HALF, 1'b0, 32'h022, 32'h0);
        checks++;
        if (obs_rdata !== 32'h0000BEEF) begin
            failures++;
            $display("FAIL lhu_022: rdata=%h required 0000beef", obs_rdata);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] w;
        w = $urandom;
        mem[4] = w; ref_mem[4] = w;
        drive_access(1'b0, SZ_WORD, 1'b0, 32'h012, 32'h0);
`ifdef MAU_ALIGN_CHECK_EN
        checks++;
        if (obs_mis !== 1'b1 || obs_we[0] !== 1'b0 || obs_rdata !== 32'h0 || obs_stall[0] !== 1'b0) begin
            failures++;
            $display("FAIL lw_012: mis=%b we=%b rdata=%h stall=%b required 1 0 0 0",
                     obs_mis, obs_we[0], obs_rdata, obs_stall[0]);
        end
`else
        checks++;
        if (obs_mis !== 1'b0 || obs_rdata !== w) begin
            failures++;
            $display("FAIL lw_012: mis=%b rdata=%h required 0 %h", obs_mis, obs_rdata, w);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        w = $urandom;
        mem[16] = w; ref_mem[16] = w;
        we_seen = 1'b0;
        mon_en  = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
        req_addr = 32'h041; req_wdata = 32'h000000A5;
        @(negedge clk);
        #1;
        checks++;
        if (dbg_state !== ST_READ || stall !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_enter: state=%0d stall=%b required %0d 1", dbg_state, stall, ST_READ);
        end
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dbg_state !== ST_IDLE || stall !== 1'b0 || dm_we !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_state: state=%0d stall=%b we=%b required 0 0 0", dbg_state, stall, dm_we);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_nop();
        drive_nop();
        mon_en = 1'b0;
        checks++;
        if (we_seen !== 1'b0 || mem[16] !== w || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL rst_mid_abort: we_seen=%b mem=%h state=%0d required 0 %h 0", we_seen, mem[16], w, dbg_state);
        end
    endtask

    task automatic test_random();
        logic        we, sg;
        logic [1:0]  sz;
        logic [31:0] a, d, exp_v;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                drive_nop();
                checks++;
                if (obs_rdata !== 32'h0 || obs_we[0] !== 1'b0 || obs_stall[0] !== 1'b0 || obs_mis !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_idle[%0d]: rdata=%h we=%b stall=%b mis=%b required 0", i,
                             obs_rdata, obs_we[0], obs_stall[0], obs_mis);
                end
                continue;
            end
            we = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = $urandom_range(0, 1023) | ($urandom & 32'hFFFF_FC00);
            d  = $urandom;
            drive_access(we, sz, sg, a, d);
            checks++;
            if (ref_misaligned(a, sz)) begin
                if (obs_mis !== 1'b1 || obs_we[0] !== 1'b0 || obs_stall[0] !== 1'b0 || obs_rdata !== 32'h0) begin
                    failures++;
                    $display("FAIL rnd_misalign[%0d]: mis=%b we=%b stall=%b rdata=%h required 1 0 0 0", i,
                             obs_mis, obs_we[0], obs_stall[0], obs_rdata);
                end
            end else if (!we) begin
                exp_v = ref_load(a, sz, sg);
                if (obs_rdata !== exp_v || obs_stall[0] !== 1'b0 || obs_we[0] !== 1'b0 || obs_mis !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_load[%0d]: a=%h sz=%0d sg=%b rdata=%h stall=%b required %h 0", i,
                             a, sz, sg, obs_rdata, obs_stall[0], exp_v);
                end
            end else if (sz[1]) begin
                ref_mem[a[9:2]] = d;
                if (obs_ncyc != 1 || obs_we[0] !== 1'b1 || obs_din !== d || obs_addr !== {a[9:2], 2'b00}) begin
                    failures++;
                    $display("FAIL rnd_sw[%0d]: cyc=%0d we=%b din=%h addr=%h required 1 1 %h %h", i,
                             obs_ncyc, obs_we[0], obs_din, obs_addr, d, {a[9:2], 2'b00});
                end
            end else begin
                exp_v = ref_merge(ref_mem[a[9:2]], a, sz, d);
                ref_mem[a[9:2]] = exp_v;
                if (obs_ncyc != 3 || {obs_stall[0], obs_stall[1], obs_stall[2]} !== 3'b110
                    || {obs_we[0], obs_we[1], obs_we[2]} !== 3'b001
                    || obs_wdin !== exp_v || obs_waddr !== {a[9:2], 2'b00}) begin
                    failures++;
                    $display("FAIL rnd_subst[%0d]: a=%h sz=%0d cyc=%0d stall=%b%b%b we=%b%b%b din=%h required 3 110 001 %h",
                             i, a, sz, obs_ncyc, obs_stall[0], obs_stall[1], obs_stall[2],
                             obs_we[0], obs_we[1], obs_we[2], obs_wdin, exp_v);
                end
            end
        end
    endtask

    task automatic test_final_mem();
        drive_nop();
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (mem[i] !== ref_mem[i]) begin
                failures++;
                $display("FAIL mem_word[%0d]: mem=%h required %h", i, mem[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_word_store();
        test_byte_store();
        test_byte_load();
        test_half_store_load();
        test_misalign();
        test_reset_mid();
        test_random();
        test_final_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
